// File: rtl/stage_rounds.sv
// ============================================================================
//  Module   : stage_rounds
//  Purpose  : Multi-round shift/add cipher stage. A WIDTH-bit word is loaded
//             and each start runs ROUNDS rounds of
//                 work <= (work << amt) + ADD_CONST
//             where amt = key_lat[KEY_W-1:2] + round, taken mod WIDTH.
//             The result goes to stg_out with a one-cycle done pulse.
//             The work register keeps the result, so back-to-back starts
//             chain runs.
//  Options  : define STAGE_ROTATE_EN to rotate left instead of shifting left
//             with zero fill. Timing and handshake are the same either way.
//  Revision : 1.0  initial multi-round release
// ============================================================================
`default_nettype none

module stage_rounds #(
    parameter int WIDTH     = 16,  // data width, power of two, >= 8
    parameter int ROUNDS    = 4,   // rounds per start, 1..255
    parameter int KEY_W     = 5,   // key width, >= 3
    parameter int ADD_CONST = 3    // per-round additive constant
) (
    input  logic             clk1,
    input  logic             rst,         // synchronous, active low
    input  logic [KEY_W-1:0] key_bits,
    input  logic [WIDTH-1:0] input_data,
    input  logic             ld,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] stg_out
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int AMT_W  = $clog2(WIDTH);   // shift amount wraps mod WIDTH
    localparam int BASE_W = KEY_W - 2;       // key field that forms the base shift
    localparam int CTR_W  = 8;               // holds round indices up to 254

    // The sum is built wide enough that no operand is truncated before the
    // final mod-WIDTH reduction.
    localparam int MAX_AB = (BASE_W > CTR_W) ? BASE_W : CTR_W;
    localparam int SUM_W  = ((MAX_AB > AMT_W) ? MAX_AB : AMT_W) + 1;

    localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(ROUNDS - 1);
    localparam logic [WIDTH-1:0] ADD_VAL    = WIDTH'(ADD_CONST);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    work;
    logic [CTR_W-1:0]    round_ctr;
    logic [BASE_W-1:0]   key_lat;

    // The two low key bits take no part in the shift amount.
    logic                unused_key_low;
    assign unused_key_low = ^key_bits[1:0];

    // ------------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------------
    logic [SUM_W-1:0]    amt_sum;
    logic [AMT_W-1:0]    amt;
    logic [WIDTH-1:0]    moved;
    logic [WIDTH-1:0]    round_result;

    // Shift amount for the current round: base from the latched key plus the
    // round index, wrapped to the data width.
    always_comb begin
        amt_sum = SUM_W'(key_lat) + SUM_W'(round_ctr);
        amt     = amt_sum[AMT_W-1:0];
    end

`ifdef STAGE_ROTATE_EN
    logic [2*WIDTH-1:0]  rot_dbl;

    // Rotate left: shifting a doubled copy brings the bits that leave the top
    // back in at the bottom of the upper half.
    always_comb begin
        rot_dbl = {work, work} << amt;
        moved   = rot_dbl[2*WIDTH-1:WIDTH];
    end
`else
    // Logical shift left with zero fill.
    always_comb begin
        moved = work << amt;
    end
`endif

    // Add the round constant; the carry out of the top bit is discarded.
    always_comb begin
        round_result = moved + ADD_VAL;
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered busy/done/stg_out
    // ------------------------------------------------------------------------
    // One round per edge while running. ld has priority over start, and both
    // are ignored in RUN. A reset during RUN abandons the run without a done.
    always_ff @(posedge clk1) begin
        if (!rst) begin
            state     <= S_IDLE;
            work      <= '0;
            round_ctr <= '0;
            key_lat   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stg_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld) begin
                        work  <= input_data;
                        state <= S_LOADED;
                    end
                end

                S_LOADED, S_DONE: begin
                    if (ld) begin
                        work  <= input_data;
                        state <= S_LOADED;
                    end else if (start) begin
                        key_lat   <= key_bits[KEY_W-1:2];
                        round_ctr <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    work <= round_result;
                    if (round_ctr == LAST_ROUND) begin
                        stg_out <= round_result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        round_ctr <= round_ctr + CTR_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
